titan_wb_stage: RTL and testbench

Writeback stage of the Titan pipeline, directly upstream of the register file. Accepts one completed instruction per cycle from the memory stage over a valid/ready handshake, aligns and extends load data, and drives the register file write port (`we`, `waddr_rd`, `wdata_rd`) from registered outputs. Also provides a same-cycle forwarding tap for decode, a retire pulse, a halt/drain state machine, and an optional retired-instruction counter.

---
 rtl/titan_wb_stage.sv | 90 +++++++++
 tb/tb_titan_wb_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/titan_wb_stage.sv
// titan_wb_stage: writeback stage driving the register file write port, with forwarding tap, halt/drain FSM and optional TITAN_INSTRET_EN retired-instruction counter
module titan_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic            mem_rd_we,
    input  logic            mem_is_load,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic            mem_exception,
    input  logic            flush,
    input  logic            halt_req,
    output logic            halted,
    output logic            wb_we,
    output logic [4:0]      wb_waddr,
    output logic [XLEN-1:0] wb_wdata,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            retire,
    output logic [63:0]     instret
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t state, state_nx;
    logic            accept;
    logic [1:0]      off;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [XLEN-1:0] ld_val;
    logic [XLEN-1:0] wr_val;
    assign mem_ready = (state == RUN) & !halt_req & !rst;
    assign halted    = (state == HALTED);
    assign accept    = mem_valid & mem_ready & !flush & !mem_exception;
    assign fwd_valid = wb_we;
    assign fwd_rd    = wb_waddr;
    assign fwd_data  = wb_wdata;
    // next state: a halt always passes through one drain cycle before halting
    always_comb begin
        state_nx = (state == RUN)   ? (halt_req ? DRAIN : RUN) :
                   (state == DRAIN) ? HALTED :
                                      (halt_req ? HALTED : RUN);
    end
    // load alignment and extension; unknown funct3 codes return the full word
    always_comb begin
        off    = mem_result[1:0];
        ld_b   = 8'(mem_load_data >> {off, 3'b000});
        ld_h   = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        ld_val = (mem_funct3 == 3'd0) ? {{(XLEN-8){ld_b[7]}}, ld_b} :
                 (mem_funct3 == 3'd4) ? {{(XLEN-8){1'b0}}, ld_b} :
                 (mem_funct3 == 3'd1) ? {{(XLEN-16){ld_h[15]}}, ld_h} :
                 (mem_funct3 == 3'd5) ? {{(XLEN-16){1'b0}}, ld_h} :
                                        mem_load_data;
        wr_val = mem_is_load ? ld_val : mem_result;
    end
    // halt/drain state register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end
    // writeback registers; address and data hold when nothing is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
            retire   <= 1'b0;
        end else begin
            wb_we  <= accept & mem_rd_we & (mem_rd != 5'd0);
            retire <= accept;
            if (accept) begin
                wb_waddr <= mem_rd;
                wb_wdata <= wr_val;
            end
        end
    end
`ifdef TITAN_INSTRET_EN
    // retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + 64'd1;
    end
`else
    assign instret = '0;
`endif
endmodule

// File: tb/tb_titan_wb_stage.sv
// tb_titan_wb_stage: table-driven and scoreboarded checks of the writeback stage
module tb_titan_wb_stage;
    logic        clk = 1'b0;
    logic        rst, mem_valid, mem_ready, mem_rd_we, mem_is_load, mem_exception, flush, halt_req, halted;
    logic [4:0]  mem_rd, wb_waddr, fwd_rd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_result, mem_load_data, wb_wdata, fwd_data;
    logic        wb_we, fwd_valid, retire;
    logic [63:0] instret;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rf [32];
`ifdef TITAN_INSTRET_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    typedef struct {
        logic        v, fl, ex, ld, we;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] res, data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ret;
    } vec_t;
    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ret;
    } exp_t;
    vec_t vecs [18];
    exp_t exp_q [$];

    titan_wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
        .mem_funct3(mem_funct3), .mem_result(mem_result), .mem_load_data(mem_load_data),
        .mem_exception(mem_exception), .flush(flush), .halt_req(halt_req), .halted(halted),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    // register file model committing the stage's write port
    always @(posedge clk) if (wb_we) rf[wb_waddr] <= wb_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic ex, input logic ld, input logic we,
                         input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] res, input logic [31:0] data);
        mem_valid = v; flush = fl; mem_exception = ex; mem_is_load = ld; mem_rd_we = we;
        mem_rd = rd; mem_funct3 = f3; mem_result = res; mem_load_data = data;
    endtask

    task automatic step_vec(input vec_t t, input int idx);
        exp_t e, g;
        drive(t.v, t.fl, t.ex, t.ld, t.we, t.rd, t.f3, t.res, t.data);
        e.we = t.e_we; e.addr = t.e_addr; e.data = t.e_data; e.ret = t.e_ret;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        g = exp_q.pop_front();
        chk($sformatf("v%0d_we", idx), 64'(wb_we), 64'(g.we));
        chk($sformatf("v%0d_addr", idx), 64'(wb_waddr), 64'(g.addr));
        chk($sformatf("v%0d_data", idx), 64'(wb_wdata), 64'(g.data));
        chk($sformatf("v%0d_ret", idx), 64'(retire), 64'(g.ret));
        chk($sformatf("v%0d_fwd", idx), {fwd_valid, 26'(0), fwd_rd, fwd_data}, {wb_we, 26'(0), g.addr, g.data});
    endtask

    initial begin
        localparam logic [31:0] D = 32'h80FF_7F01;
        //          v  fl ex ld we rd  f3    res            data   e_we e_addr e_data        e_ret
        vecs[0]  = '{1, 0, 0, 0, 1, 5,  3'd0, 32'h1234_5678, D,     1, 5,  32'h1234_5678, 1};
        vecs[1]  = '{1, 0, 0, 1, 1, 1,  3'd0, 32'h0000_1003, D,     1, 1,  32'hFFFF_FF80, 1};
        vecs[2]  = '{1, 0, 0, 1, 1, 2,  3'd4, 32'h0000_1001, D,     1, 2,  32'h0000_007F, 1};
        vecs[3]  = '{1, 0, 0, 1, 1, 3,  3'd1, 32'h0000_1002, D,     1, 3,  32'hFFFF_80FF, 1};
        vecs[4]  = '{1, 0, 0, 1, 1, 4,  3'd5, 32'h0000_1000, D,     1, 4,  32'h0000_7F01, 1};
        vecs[5]  = '{1, 0, 0, 1, 1, 6,  3'd2, 32'h0000_1000, D,     1, 6,  32'h80FF_7F01, 1};
        vecs[6]  = '{1, 0, 0, 1, 1, 7,  3'd1, 32'h0000_1003, D,     1, 7,  32'hFFFF_80FF, 1};
        vecs[7]  = '{1, 0, 0, 1, 1, 8,  3'd0, 32'h0000_1000, D,     1, 8,  32'h0000_0001, 1};
        vecs[8]  = '{1, 0, 0, 1, 1, 9,  3'd5, 32'h0000_1002, D,     1, 9,  32'h0000_80FF, 1};
        vecs[9]  = '{1, 0, 0, 1, 1, 11, 3'd3, 32'h0000_1001, D,     1, 11, 32'h80FF_7F01, 1};
        vecs[10] = '{1, 0, 0, 1, 1, 12, 3'd7, 32'h0000_1003, D,     1, 12, 32'h80FF_7F01, 1};
        vecs[11] = '{1, 0, 0, 0, 1, 0,  3'd0, 32'h0000_DEAD, D,     0, 0,  32'h0000_DEAD, 1};
        vecs[12] = '{1, 0, 0, 0, 0, 13, 3'd0, 32'h0000_BEEF, D,     0, 13, 32'h0000_BEEF, 1};
        vecs[13] = '{1, 0, 1, 0, 1, 14, 3'd0, 32'h0000_1111, D,     0, 13, 32'h0000_BEEF, 0};
        vecs[14] = '{1, 1, 0, 0, 1, 15, 3'd0, 32'h0000_2222, D,     0, 13, 32'h0000_BEEF, 0};
        vecs[15] = '{0, 0, 0, 0, 1, 16, 3'd0, 32'h0000_3333, D,     0, 13, 32'h0000_BEEF, 0};
        vecs[16] = '{1, 0, 0, 0, 1, 16, 3'd0, 32'hAABB_CCDD, D,     1, 16, 32'hAABB_CCDD, 1};
        vecs[17] = '{1, 0, 0, 1, 1, 17, 3'd4, 32'h0000_1003, D,     1, 17, 32'h0000_0080, 1};

        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b1; halt_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_state", {wb_we, retire, halted, wb_waddr, wb_wdata}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        rst = 1'b0;
        #1 chk("ready_after_rst", 64'(mem_ready), 64'd1);

        for (int i = 0; i < 18; i++) step_vec(vecs[i], i);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("instret_table", instret, CNT ? 64'd15 : 64'd0);
        chk("rf_x5", 64'(rf[5]), 64'h1234_5678);
        chk("rf_x1", 64'(rf[1]), 64'hFFFF_FF80);
        chk("rf_x0", 64'(rf[0]), 64'd0);
        chk("rf_x14", 64'(rf[14]), 64'd0);

        // halt while streaming
        drive(1, 0, 0, 0, 1, 20, 0, 32'h55, 0);
        @(negedge clk);
        chk("h_staged_we", {wb_we, 3'b0, wb_waddr}, {1'b1, 3'b0, 5'd20});
        halt_req = 1'b1;
        drive(1, 0, 0, 0, 1, 21, 0, 32'h66, 0);
        #1 chk("h_ready_drop", 64'(mem_ready), 64'd0);
        @(negedge clk);
        chk("h_drain", {halted, wb_we, retire, mem_ready}, 4'b0000);
        chk("h_commit", 64'(rf[20]), 64'h55);
        halt_req = 1'b0;
        #1 chk("h_drain_ready", 64'(mem_ready), 64'd0);
        @(negedge clk);
        chk("h_halted", {halted, mem_ready}, 2'b10);
        @(negedge clk);
        chk("h_release", {halted, mem_ready}, 2'b01);
        @(negedge clk);
        chk("h_resume", {wb_we, wb_waddr, wb_wdata}, {1'b1, 5'd21, 32'h66});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        halt_req = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("h2_halted", 64'(halted), 64'd1);
        @(negedge clk);
        chk("h2_hold", {halted, mem_ready}, 2'b10);
        halt_req = 1'b0;
        @(negedge clk);
        chk("h2_release", {halted, mem_ready}, 2'b01);
        chk("instret_halt", instret, CNT ? 64'd17 : 64'd0);

        // counter over 10 back-to-back retires, then reset mid-stream
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("c_zero", instret, 64'd0);
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 0, 0, 1, 5'(i), 0, 32'(i), 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("c_ten", instret, CNT ? 64'd10 : 64'd0);
        drive(1, 0, 0, 0, 1, 3, 0, 32'h77, 0);
        @(negedge clk);
        chk("c_pre_rst_we", {wb_we, retire}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("c_rst_out", {wb_we, retire, wb_waddr, wb_wdata}, 64'd0);
        chk("c_rst_cnt", instret, 64'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("c_idle", {wb_we, retire}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
